// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single hal memory port, with a busy-start timeout.
// Define MEM_ARB_CPU_PRIORITY_EN to give port A fixed priority instead of round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUSY_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_read_req,
    input  logic              a_write_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_done,
    output logic              a_err,
    input  logic              b_read_req,
    input  logic              b_write_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic              b_err,
    output logic              memory_read_req,
    output logic              memory_write_req,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [DATA_W-1:0] memory_data_write,
    input  logic [DATA_W-1:0] memory_data_read,
    input  logic              memory_busy,
    output logic [2:0]        arb_state
);

    localparam int unsigned CntW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssue    = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StComplete = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              grant_b_q, grant_b_d;
    logic              op_write_q, op_write_d;
    logic              both_q, both_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic a_req, b_req, pick_b, sel_rd, sel_wr;

    assign a_req = a_read_req | a_write_req;
    assign b_req = b_read_req | b_write_req;

`ifdef MEM_ARB_CPU_PRIORITY_EN
    assign pick_b = ~a_req;
`else
    logic last_grant_b_q;

    // On a tie, grant whichever port was not served last.
    assign pick_b = b_req & (~a_req | ~last_grant_b_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_b_q <= 1'b1;
        end else if (state_q == StIdle && (a_req || b_req)) begin
            last_grant_b_q <= pick_b;
        end
    end
`endif

    assign sel_rd = pick_b ? b_read_req  : a_read_req;
    assign sel_wr = pick_b ? b_write_req : a_write_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_b_q  <= 1'b0;
            op_write_q <= 1'b0;
            both_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_b_q  <= grant_b_d;
            op_write_q <= op_write_d;
            both_q     <= both_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_b_d  = grant_b_q;
        op_write_d = op_write_q;
        both_d     = both_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    grant_b_d  = pick_b;
                    op_write_d = ~sel_rd;
                    both_d     = sel_rd & sel_wr;
                    addr_d     = pick_b ? b_addr  : a_addr;
                    wdata_d    = pick_b ? b_wdata : a_wdata;
                    timeout_d  = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                state_d   = StWaitBusy;
            end
            StWaitBusy: begin
                // The flag is registered first, so the give-up happens one cycle after it sets.
                if (timeout_q) begin
                    state_d = StComplete;
                end else if (memory_busy) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(BUSY_WAIT - 1)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (!memory_busy) begin
                    if (!op_write_q) begin
                        if (grant_b_q) b_rdata_d = memory_data_read;
                        else           a_rdata_d = memory_data_read;
                    end
                    state_d = StComplete;
                end
            end
            StComplete: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        memory_read_req   = (state_q == StIssue) & ~op_write_q;
        memory_write_req  = (state_q == StIssue) &  op_write_q;
        memory_addr       = addr_q;
        memory_data_write = wdata_q;
        a_done            = (state_q == StComplete) & ~grant_b_q;
        b_done            = (state_q == StComplete) &  grant_b_q;
        a_err             = a_done & (timeout_q | both_q);
        b_err             = b_done & (timeout_q | both_q);
        a_rdata           = a_rdata_q;
        b_rdata           = b_rdata_q;
        arb_state         = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small hal model that raises busy the cycle after a pulse.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W    = 26;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BUSY_WAIT = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_read_req, a_write_req, b_read_req, b_write_req;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              a_done, a_err, b_done, b_err;
    logic              memory_read_req, memory_write_req;
    logic [ADDR_W-1:0] memory_addr;
    logic [DATA_W-1:0] memory_data_write;
    logic [DATA_W-1:0] memory_data_read;
    logic              memory_busy;
    logic [2:0]        arb_state;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BUSY_WAIT(BUSY_WAIT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .a_read_req       (a_read_req),
        .a_write_req      (a_write_req),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_rdata          (a_rdata),
        .a_done           (a_done),
        .a_err            (a_err),
        .b_read_req       (b_read_req),
        .b_write_req      (b_write_req),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_rdata          (b_rdata),
        .b_done           (b_done),
        .b_err            (b_err),
        .memory_read_req  (memory_read_req),
        .memory_write_req (memory_write_req),
        .memory_addr      (memory_addr),
        .memory_data_write(memory_data_write),
        .memory_data_read (memory_data_read),
        .memory_busy      (memory_busy),
        .arb_state        (arb_state)
    );

    always #5 clk = ~clk;

    // hal model
    int unsigned busy_len  = 3;
    logic        hal_dead  = 1'b0;
    logic [31:0] hal_rdata = '0;
    int unsigned busy_cnt  = 0;

    assign memory_busy      = (busy_cnt != 0);
    assign memory_data_read = hal_rdata;

    always @(posedge clk) begin
        if ((memory_read_req || memory_write_req) && !hal_dead) busy_cnt <= busy_len;
        else if (busy_cnt != 0)                                  busy_cnt <= busy_cnt - 1;
    end

    // Monitor samples each cycle's settled values at the edge that ends it.
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_ovl = 0, n_adone = 0, n_bdone = 0;
    int          rd_cyc = 0, wr_cyc = 0, fall_cyc = 0;
    logic [25:0] rd_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy_prev = 1'b0;
    int          order[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memory_read_req) begin
            n_rd <= n_rd + 1; rd_cyc <= cyc; rd_addr <= memory_addr;
        end
        if (memory_write_req) begin
            n_wr <= n_wr + 1; wr_cyc <= cyc; wr_addr <= memory_addr; wr_data <= memory_data_write;
        end
        if (memory_read_req && memory_write_req) n_ovl <= n_ovl + 1;
        if (a_done) begin n_adone <= n_adone + 1; order.push_back(0); end
        if (b_done) begin n_bdone <= n_bdone + 1; order.push_back(1); end
        if (!memory_busy && busy_prev) fall_cyc <= cyc;
        busy_prev <= memory_busy;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input bit port_b, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (port_b ? b_done : a_done) begin
                ok = 1'b1;
                break;
            end
        end
        check(port_b ? "wait_b_done" : "wait_a_done", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        a_read_req  = 1'b0; a_write_req = 1'b0;
        b_read_req  = 1'b0; b_write_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        int rd0, wr0, ad0, bd0, base, ad_c, bd_c, ndone;
        bit got_a, got_b;
        logic [31:0] exp_order [4];

        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        do_reset();

        // Reset state
        check("rst_state", 64'(arb_state), 64'd0);
        check("rst_addr", 64'(memory_addr), 64'd0);
        check("rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        check("rst_pulses", 64'({memory_read_req, memory_write_req, a_done, b_done}), 64'd0);

        // Port A read, busy held 3 cycles
        hal_rdata = 32'hDEADBEEF; busy_len = 3;
        rd0 = n_rd; bd0 = n_bdone;
        a_addr = 26'h0000100; a_read_req = 1'b1;
        wait_done(1'b0, 40, ok);
        a_read_req = 1'b0;
        check("t1_rdata", 64'(a_rdata), 64'hDEADBEEF);
        check("t1_err", 64'(a_err), 64'd0);
        check("t1_done_after_fall", 64'(cyc - fall_cyc), 64'd1);
        tick(2);
        check("t1_rd_pulses", 64'(n_rd - rd0), 64'd1);
        check("t1_rd_addr", 64'(rd_addr), 64'h100);
        check("t1_no_b_done", 64'(n_bdone - bd0), 64'd0);

        // Simultaneous A write and B read after reset: A first
        do_reset();
        hal_rdata = 32'hCAFEF00D;
        rd0 = n_rd; wr0 = n_wr;
        a_addr = 26'h10; a_wdata = 32'h12345678; a_write_req = 1'b1;
        b_addr = 26'h20; b_read_req = 1'b1;
        got_a = 1'b0; got_b = 1'b0; ad_c = 0; bd_c = 0;
        for (int i = 0; i < 100 && !(got_a && got_b); i++) begin
            @(negedge clk);
            if (a_done) begin a_write_req = 1'b0; ad_c = cyc; got_a = 1'b1; end
            if (b_done) begin b_read_req = 1'b0; bd_c = cyc; got_b = 1'b1; end
        end
        tick(1);
        check("t2_both_done", 64'({got_a, got_b}), 64'b11);
        check("t2_wr_pulses", 64'(n_wr - wr0), 64'd1);
        check("t2_rd_pulses", 64'(n_rd - rd0), 64'd1);
        check("t2_wr_addr", 64'(wr_addr), 64'h10);
        check("t2_wr_data", 64'(wr_data), 64'h12345678);
        check("t2_rd_addr", 64'(rd_addr), 64'h20);
        check("t2_a_first", 64'(ad_c < bd_c), 64'd1);
        check("t2_wr_before_rd", 64'(wr_cyc < rd_cyc), 64'd1);
        check("t2_b_rdata", 64'(b_rdata), 64'hCAFEF00D);
        check("t2_no_overlap", 64'(n_ovl), 64'd0);

        // Both ports hold requests for 4 transactions
        hal_rdata = 32'h0BADF00D; busy_len = 2;
        base = order.size(); ndone = 0;
        a_addr = 26'h30; b_addr = 26'h40;
        a_read_req = 1'b1; b_read_req = 1'b1;
        for (int i = 0; i < 200 && ndone < 4; i++) begin
            @(negedge clk);
            if (a_done || b_done) ndone++;
            if (ndone == 4) begin a_read_req = 1'b0; b_read_req = 1'b0; end
        end
        a_read_req = 1'b0; b_read_req = 1'b0;
        tick(2);
`ifdef MEM_ARB_CPU_PRIORITY_EN
        exp_order = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
        exp_order = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif
        check("t3_count", 64'(order.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_grant%0d", i),
                  64'((order.size() > base + i) ? order[base + i] : 9), 64'(exp_order[i]));
        end

        // hal never raises busy: timeout
        hal_dead = 1'b1; hal_rdata = 32'h11111111;
        a_addr = 26'h50; a_read_req = 1'b1;
        wait_done(1'b0, 60, ok);
        a_read_req = 1'b0;
        check("t4_err", 64'(a_err), 64'd1);
        check("t4_latency", 64'(cyc - rd_cyc), 64'(BUSY_WAIT + 2));
        check("t4_rdata_kept", 64'(a_rdata), 64'h0BADF00D);
        tick(1);
        check("t4_idle", 64'(arb_state), 64'd0);
        hal_dead = 1'b0; hal_rdata = 32'h55AA55AA;
        a_read_req = 1'b1;
        wait_done(1'b0, 40, ok);
        a_read_req = 1'b0;
        check("t4_next_err", 64'(a_err), 64'd0);
        check("t4_next_rdata", 64'(a_rdata), 64'h55AA55AA);

        // Port B asserts read and write together
        tick(2);
        hal_rdata = 32'h00000077;
        rd0 = n_rd; wr0 = n_wr; ad0 = n_adone;
        b_addr = 26'h60; b_read_req = 1'b1; b_write_req = 1'b1;
        wait_done(1'b1, 40, ok);
        check("t5_b_err", 64'(b_err), 64'd1);
        b_read_req = 1'b0; b_write_req = 1'b0;
        tick(2);
        check("t5_rd_pulses", 64'(n_rd - rd0), 64'd1);
        check("t5_wr_pulses", 64'(n_wr - wr0), 64'd0);
        check("t5_b_rdata", 64'(b_rdata), 64'h77);
        check("t5_no_a_done", 64'(n_adone - ad0), 64'd0);

        // Reset during WAIT_DONE
        busy_len = 10;
        a_addr = 26'h70; a_read_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arb_state == 3'd3) begin ok = 1'b1; break; end
        end
        check("t6_reached_wait_done", 64'(ok), 64'd1);
        reset_n = 1'b0; a_read_req = 1'b0;
        #1;
        check("t6_state", 64'(arb_state), 64'd0);
        check("t6_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        check("t6_addr", 64'(memory_addr), 64'd0);
        check("t6_done", 64'({a_done, b_done, a_err, b_err}), 64'd0);
        ad0 = n_adone;
        tick(2);
        reset_n = 1'b1;
        tick(15);
        check("t6_no_done_after", 64'(n_adone - ad0), 64'd0);
        hal_rdata = 32'h00000099; busy_len = 2;
        b_addr = 26'h80; b_read_req = 1'b1;
        wait_done(1'b1, 40, ok);
        b_read_req = 1'b0;
        check("t6_new_rdata", 64'(b_rdata), 64'h99);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
